clk_period_meter: RTL

Measures the period and high time of a slow, asynchronous square wave in system-clock cycles, such as the output of the team's clock dividers or an external tick. It is the receiving end of a divided clock. A measurement starts on request, completes on the second rising edge of the input, and reports the results with a one-cycle valid pulse. A timeout aborts the measurement when the input is stuck. The block sits beside the divider instances as a self-check and calibration aid.

---
 rtl/clk_meter_pkg.sv | 16 +
 rtl/edge_sync.sv | 34 +++
 rtl/clk_period_meter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/clk_meter_pkg.sv
// Shared types and defaults for the clock period meter.
// State encoding plus default parameter values.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    localparam int CNT_W_DEF       = 16;
    localparam int TIMEOUT_DEF     = 65535;
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/edge_sync.sv
// Synchroniser chain plus history flop for an asynchronous input.
// Produces single-cycle rise and fall strobes in the clk domain.
module edge_sync
    import clk_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_hist <= w_sync;
        end
    end

    assign rise = w_sync & ~r_hist;
    assign fall = ~w_sync & r_hist;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow square wave in clk cycles.
// Start-triggered, with timeout abort when the input stops toggling.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             timeout,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LP_TO  = CNT_W'(TIMEOUT);

    logic             w_rise;
    logic             w_fall;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_fall_seen;
    logic             w_fall_seen_nxt;
    logic [CNT_W-1:0] r_ht_cap;
    logic [CNT_W-1:0] w_ht_cap_nxt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_period_nxt;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] w_high_nxt;
    logic             w_timeout;
    logic             w_valid;

    edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .sig_in(sig_in),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_fall_seen <= 1'b0;
            r_ht_cap    <= '0;
            r_period    <= '0;
            r_high      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fall_seen <= w_fall_seen_nxt;
            r_ht_cap    <= w_ht_cap_nxt;
            r_period    <= w_period_nxt;
            r_high      <= w_high_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_fall_seen_nxt = r_fall_seen;
        w_ht_cap_nxt    = r_ht_cap;
        w_period_nxt    = r_period;
        w_high_nxt      = r_high;
        w_timeout       = 1'b0;
        w_valid         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_cnt_nxt   = LP_ONE;
                    w_state_nxt = WAIT_RISE;
                end
            end
            WAIT_RISE: begin
                if (w_rise) begin
                    w_cnt_nxt       = LP_ONE;
                    w_fall_seen_nxt = 1'b0;
                    w_state_nxt     = MEASURE;
                end else if (r_cnt == LP_TO) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
            MEASURE: begin
                if (w_fall && !r_fall_seen) begin
                    w_ht_cap_nxt    = r_cnt;
                    w_fall_seen_nxt = 1'b1;
                end
                // High time is shadowed so an aborted run leaves outputs intact
                if (w_rise) begin
                    w_period_nxt = r_cnt;
                    w_high_nxt   = r_fall_seen ? r_ht_cap : '0;
                    w_state_nxt  = DONE;
                end else if (r_cnt == LP_TO) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
            DONE: begin
                w_valid     = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign period       = r_period;
    assign high_time    = r_high;
    assign period_valid = w_valid;
    assign timeout      = w_timeout;
    assign busy         = (r_state != IDLE);

endmodule
